// File: rtl/fmul_arb_pkg.sv
// rtl/fmul_arb_pkg.sv - shared state encoding and widths for the multiplier arbiter
package fmul_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    WAIT_Z = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting one past the last winner
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_idx
);

  always_comb begin
    logic            w_found;
    logic [ID_W-1:0] w_j;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    // Visit ptr+1 .. ptr+N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      w_j = ID_W'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - shares one stb/ack FP multiplier between NUM_REQ requesters
module fmul_arbiter
  import fmul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_z,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  output logic                    mul_a_stb,
  output logic                    mul_b_stb,
  input  logic                    mul_a_ack,
  input  logic                    mul_b_ack,
  input  logic [FP_W-1:0]         mul_z,
  input  logic                    mul_z_stb,
  output logic                    mul_z_ack,
  output logic                    busy,
  output logic [31:0]             op_count
);

  state_t              r_state;
  logic [FP_W-1:0]     r_a;
  logic [FP_W-1:0]     r_b;
  logic [ID_W-1:0]     r_gnt;
  logic [ID_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [FP_W-1:0]     r_resp_z;
  logic [ID_W-1:0]     r_resp_id;
  logic [31:0]         r_op_count;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_idx;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Gated by rst so nothing is offered while the block is held in reset.
  assign req_ready  = (r_state == IDLE && rst) ? w_gnt : '0;
  assign mul_a_stb  = (r_state == SEND_A);
  assign mul_b_stb  = (r_state == SEND_B);
  assign mul_z_ack  = (r_state == WAIT_Z);
  assign busy       = (r_state != IDLE);
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign resp_valid = r_resp_valid;
  assign resp_z     = r_resp_z;
  assign resp_id    = r_resp_id;
  assign op_count   = r_op_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_gnt        <= '0;
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_resp_valid <= '0;
      r_resp_z     <= '0;
      r_resp_id    <= '0;
      r_op_count   <= '0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (|req_ready) begin
            r_a     <= req_a[FP_W*w_idx +: FP_W];
            r_b     <= req_b[FP_W*w_idx +: FP_W];
            r_gnt   <= w_idx;
            r_ptr   <= w_idx;
            r_state <= SEND_A;
          end
        end
        SEND_A: if (mul_a_ack) r_state <= SEND_B;
        SEND_B: if (mul_b_ack) r_state <= WAIT_Z;
        WAIT_Z: begin
          if (mul_z_stb) begin
            r_resp_z     <= mul_z;
            r_resp_id    <= r_gnt;
            r_resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt;
            r_op_count   <= r_op_count + 32'd1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
